// File: rtl/csr_trap_ctrl_if.sv
// CSR access bundle: pipeline-side request/response and CSR-file-side port.
interface csr_trap_ctrl_if #(
    parameter int unsigned XLEN = 64
);
    // pipeline side
    logic [11:0]     inst_csr_addr;
    logic            inst_csr_rena;
    logic            inst_csr_wena;
    logic [1:0]      inst_csr_op;
    logic [XLEN-1:0] inst_csr_wdata;
    logic [XLEN-1:0] inst_csr_rdata;

    // CSR file side
    logic [11:0]     csr_addr;
    logic            csr_rena;
    logic            csr_wena;
    logic [1:0]      csr_op;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;

    // controller view
    modport master (
        input  inst_csr_addr, inst_csr_rena, inst_csr_wena, inst_csr_op, inst_csr_wdata,
        input  csr_rdata,
        output inst_csr_rdata,
        output csr_addr, csr_rena, csr_wena, csr_op, csr_wdata
    );

    // pipeline + CSR file view
    modport slave (
        output inst_csr_addr, inst_csr_rena, inst_csr_wena, inst_csr_op, inst_csr_wdata,
        output csr_rdata,
        input  inst_csr_rdata,
        input  csr_addr, csr_rena, csr_wena, csr_op, csr_wdata
    );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Sequencer owning the CSR file port: passes pipeline accesses through when idle,
// otherwise runs the trap entry / mret CSR sequences and issues one PC redirect.
module csr_trap_ctrl #(
    parameter int unsigned XLEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_req,
    input  logic [XLEN-1:0]   trap_cause,
    input  logic [XLEN-1:0]   trap_pc,
    input  logic              mret_req,
    csr_trap_ctrl_if.master   bus,
    output logic              busy,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc
);

    localparam logic [1:0]      CSR_RW     = 2'b01;
    localparam logic [11:0]     A_MSTATUS  = 12'h300;
    localparam logic [11:0]     A_MTVEC    = 12'h305;
    localparam logic [11:0]     A_MEPC     = 12'h341;
    localparam logic [11:0]     A_MCAUSE   = 12'h342;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic [3:0] {
        S_IDLE,
        S_EPC,
        S_CAUSE,
        S_RDST,
        S_WRST,
        S_RDTV,
        S_M_RDST,
        S_M_WRST,
        S_M_RDEPC,
        S_REDIR
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] st_q;

    logic [XLEN-1:0] trap_st;
    logic [XLEN-1:0] mret_st;
    logic [XLEN-1:0] tv_base;
    logic [XLEN-1:0] tv_off;
    logic [XLEN-1:0] tv_target;

    // mstatus images written on trap entry and on mret
    always_comb begin
        trap_st         = st_q;
        trap_st[7]      = st_q[3];
        trap_st[3]      = 1'b0;
        trap_st[12:11]  = 2'b11;
        mret_st         = st_q;
        mret_st[3]      = st_q[7];
        mret_st[7]      = 1'b1;
        mret_st[12:11]  = 2'b00;
    end

    // trap vector: vectored mode only offsets interrupts; add wraps at XLEN bits
    assign tv_base   = bus.csr_rdata & ALIGN_MASK;
    assign tv_off    = XLEN'({cause_q[5:0], 2'b00});
    assign tv_target = ((bus.csr_rdata[1:0] == 2'b01) && cause_q[XLEN-1])
                     ? (tv_base + tv_off) : tv_base;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // next-state logic; trap wins over mret, requests ignored outside idle
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (trap_req)      state_nxt = S_EPC;
                else if (mret_req) state_nxt = S_M_RDST;
            end
            S_EPC:     state_nxt = S_CAUSE;
            S_CAUSE:   state_nxt = S_RDST;
            S_RDST:    state_nxt = S_WRST;
            S_WRST:    state_nxt = S_RDTV;
            S_RDTV:    state_nxt = S_REDIR;
            S_M_RDST:  state_nxt = S_M_WRST;
            S_M_WRST:  state_nxt = S_M_RDEPC;
            S_M_RDEPC: state_nxt = S_REDIR;
            S_REDIR:   state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // CSR port drive; enables are held off while reset is asserted so an
    // abandoned sequence never lands its pending write
    always_comb begin
        bus.csr_addr       = '0;
        bus.csr_rena       = 1'b0;
        bus.csr_wena       = 1'b0;
        bus.csr_op         = CSR_RW;
        bus.csr_wdata      = '0;
        bus.inst_csr_rdata = '0;
        busy               = (state != S_IDLE);
        redirect_valid     = (state == S_REDIR);
        if (!rst) begin
            unique case (state)
                S_IDLE: begin
                    bus.csr_addr       = bus.inst_csr_addr;
                    bus.csr_rena       = bus.inst_csr_rena;
                    bus.csr_wena       = bus.inst_csr_wena & ~trap_req;
                    bus.csr_op         = bus.inst_csr_op;
                    bus.csr_wdata      = bus.inst_csr_wdata;
                    bus.inst_csr_rdata = bus.inst_csr_rena ? bus.csr_rdata : '0;
                end
                S_EPC: begin
                    bus.csr_addr  = A_MEPC;
                    bus.csr_wena  = 1'b1;
                    bus.csr_wdata = pc_q;
                end
                S_CAUSE: begin
                    bus.csr_addr  = A_MCAUSE;
                    bus.csr_wena  = 1'b1;
                    bus.csr_wdata = cause_q;
                end
                S_RDST, S_M_RDST: begin
                    bus.csr_addr = A_MSTATUS;
                    bus.csr_rena = 1'b1;
                end
                S_WRST: begin
                    bus.csr_addr  = A_MSTATUS;
                    bus.csr_wena  = 1'b1;
                    bus.csr_wdata = trap_st;
                end
                S_RDTV: begin
                    bus.csr_addr = A_MTVEC;
                    bus.csr_rena = 1'b1;
                end
                S_M_WRST: begin
                    bus.csr_addr  = A_MSTATUS;
                    bus.csr_wena  = 1'b1;
                    bus.csr_wdata = mret_st;
                end
                S_M_RDEPC: begin
                    bus.csr_addr = A_MEPC;
                    bus.csr_rena = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // sequence latches and redirect target
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= '0;
            cause_q     <= '0;
            st_q        <= '0;
            redirect_pc <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (trap_req) begin
                        pc_q    <= trap_pc & ALIGN_MASK;
                        cause_q <= trap_cause;
                    end
                end
                S_RDST, S_M_RDST: st_q        <= bus.csr_rdata;
                S_RDTV:           redirect_pc <= tv_target;
                S_M_RDEPC:        redirect_pc <= bus.csr_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Scoreboard bench: stimulus pushes expected CSR writes / redirects, a negedge
// monitor pops and compares whenever the DUT drives csr_wena or redirect_valid.
module tb_csr_trap_ctrl;

    localparam int unsigned XLEN = 64;

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  op;
        logic [63:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [63:0] pc;
        int          cyc;
    } rd_t;

    logic            clk;
    logic            rst;
    logic            trap_req;
    logic [63:0]     trap_cause;
    logic [63:0]     trap_pc;
    logic            mret_req;
    logic            busy;
    logic            redirect_valid;
    logic [63:0]     redirect_pc;

    csr_trap_ctrl_if #(.XLEN(XLEN)) bus ();

    csr_trap_ctrl #(.XLEN(XLEN)) dut (
        .clk            (clk),
        .rst            (rst),
        .trap_req       (trap_req),
        .trap_cause     (trap_cause),
        .trap_pc        (trap_pc),
        .mret_req       (mret_req),
        .bus            (bus),
        .busy           (busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    wr_t wr_q[$];
    rd_t rd_q[$];
    wr_t mon_w;
    rd_t mon_r;

    // CSR file model with a backdoor preload port
    logic [63:0] mem [0:4095];
    logic        bd_we;
    logic [11:0] bd_addr;
    logic [63:0] bd_data;

    assign bus.csr_rdata = bus.csr_rena ? mem[bus.csr_addr] : 64'h0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (bus.csr_wena) begin
            case (bus.csr_op)
                2'b01: mem[bus.csr_addr] <= bus.csr_wdata;
                2'b10: mem[bus.csr_addr] <= mem[bus.csr_addr] | bus.csr_wdata;
                2'b11: mem[bus.csr_addr] <= mem[bus.csr_addr] & ~bus.csr_wdata;
                default: ;
            endcase
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every CSR write and every redirect pulse must match the queue head
    always @(negedge clk) begin
        if (bus.csr_wena === 1'b1) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h (cycle %0d), none expected",
                         bus.csr_addr, bus.csr_wdata, cyc);
            end else begin
                mon_w = wr_q.pop_front();
                check("wr_addr", 64'(bus.csr_addr), 64'(mon_w.addr));
                check("wr_op",   64'(bus.csr_op),   64'(mon_w.op));
                check("wr_data", bus.csr_wdata,     mon_w.data);
                check("wr_cycle", 64'(cyc),         64'(mon_w.cyc));
            end
        end
        if (redirect_valid === 1'b1) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_redirect: pc %h (cycle %0d), none expected", redirect_pc, cyc);
            end else begin
                mon_r = rd_q.pop_front();
                check("redir_pc",    redirect_pc, mon_r.pc);
                check("redir_cycle", 64'(cyc),    64'(mon_r.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [11:0] a, input logic [63:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        tick();
        bd_we   = 1'b0;
    endtask

    task automatic clear_inst();
        bus.inst_csr_addr  = 12'h0;
        bus.inst_csr_rena  = 1'b0;
        bus.inst_csr_wena  = 1'b0;
        bus.inst_csr_op    = 2'b00;
        bus.inst_csr_wdata = 64'h0;
    endtask

    // expected writes/redirect of one trap sequence accepted in cycle n
    task automatic exp_trap(input int n, input logic [63:0] epc, input logic [63:0] cause,
                            input logic [63:0] st, input logic [63:0] target);
        wr_q.push_back('{12'h341, 2'b01, epc,   n + 1});
        wr_q.push_back('{12'h342, 2'b01, cause, n + 2});
        wr_q.push_back('{12'h300, 2'b01, st,    n + 4});
        rd_q.push_back('{target, n + 6});
    endtask

    // walk a sequence from its accept cycle, checking busy and idle write gating
    task automatic watch_busy(input int last);
        for (int i = 0; i <= last + 1; i++) begin
            @(negedge clk);
            check($sformatf("busy_c%0d", i), 64'(busy), 64'((i >= 1) && (i <= last)));
            if (i == 0) check("accept_wena", 64'(bus.csr_wena), 64'h0);
            if (i == 1) begin
                trap_req = 1'b0;
                mret_req = 1'b0;
                clear_inst();
            end
        end
    endtask

    int n;

    initial begin
        rst        = 1'b1;
        trap_req   = 1'b0;
        mret_req   = 1'b0;
        trap_cause = 64'h0;
        trap_pc    = 64'h0;
        bd_we      = 1'b0;
        bd_addr    = 12'h0;
        bd_data    = 64'h0;
        clear_inst();

        // reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_busy",   64'(busy), 64'h0);
        check("rst_rvalid", 64'(redirect_valid), 64'h0);
        check("rst_rpc",    redirect_pc, 64'h0);
        check("rst_rena",   64'(bus.csr_rena), 64'h0);
        check("rst_wena",   64'(bus.csr_wena), 64'h0);
        check("rst_irdata", bus.inst_csr_rdata, 64'h0);
        tick();
        rst = 1'b0;

        // reset mid-trap: abandoned in S_CAUSE, mcause untouched
        poke(12'h342, 64'hAA);
        poke(12'h300, 64'h8);
        poke(12'h305, 64'h8000_0100);
        trap_req   = 1'b1;
        trap_pc    = 64'h8000_0046;
        trap_cause = 64'h2;
        n = cyc;
        wr_q.push_back('{12'h341, 2'b01, 64'h8000_0044, n + 1});
        tick();
        trap_req = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_wena", 64'(bus.csr_wena), 64'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy",   64'(busy), 64'h0);
        check("midrst_rvalid", 64'(redirect_valid), 64'h0);
        check("midrst_wena",   64'(bus.csr_wena), 64'h0);
        check("midrst_rpc",    redirect_pc, 64'h0);
        check("midrst_mcause", mem[12'h342], 64'hAA);
        repeat (3) tick();

        // direct trap
        trap_req   = 1'b1;
        trap_pc    = 64'h8000_0046;
        trap_cause = 64'h2;
        n = cyc;
        exp_trap(n, 64'h8000_0044, 64'h2, 64'h1880, 64'h8000_0100);
        watch_busy(6);
        tick();

        // vectored interrupt
        poke(12'h305, 64'h8000_0101);
        trap_req   = 1'b1;
        trap_pc    = 64'h8000_0200;
        trap_cause = 64'h8000_0000_0000_0007;
        n = cyc;
        exp_trap(n, 64'h8000_0200, 64'h8000_0000_0000_0007, 64'h1800, 64'h8000_011C);
        watch_busy(6);
        repeat (3) tick();
        check("rpc_hold", redirect_pc, 64'h8000_011C);

        // mret
        poke(12'h300, 64'h1880);
        poke(12'h341, 64'h8000_0044);
        mret_req = 1'b1;
        n = cyc;
        wr_q.push_back('{12'h300, 2'b01, 64'h88, n + 2});
        rd_q.push_back('{64'h8000_0044, n + 4});
        watch_busy(4);
        tick();

        // trap + mret + pipeline write together: trap wins, write suppressed
        poke(12'hB00, 64'h1234);
        trap_req           = 1'b1;
        mret_req           = 1'b1;
        trap_pc            = 64'h8000_0010;
        trap_cause         = 64'h2;
        bus.inst_csr_addr  = 12'hB00;
        bus.inst_csr_wena  = 1'b1;
        bus.inst_csr_op    = 2'b01;
        bus.inst_csr_wdata = 64'h55;
        n = cyc;
        exp_trap(n, 64'h8000_0010, 64'h2, 64'h1880, 64'h8000_0100);
        watch_busy(6);
        repeat (4) tick();
        check("sim_cycle_csr", mem[12'hB00], 64'h1234);

        // idle pass-through read and RS write
        bus.inst_csr_addr = 12'hB00;
        bus.inst_csr_rena = 1'b1;
        @(negedge clk);
        check("pt_rdata", bus.inst_csr_rdata, 64'h1234);
        check("pt_rena",  64'(bus.csr_rena), 64'h1);
        tick();
        clear_inst();
        bus.inst_csr_addr  = 12'hB00;
        bus.inst_csr_wena  = 1'b1;
        bus.inst_csr_op    = 2'b10;
        bus.inst_csr_wdata = 64'hF0;
        wr_q.push_back('{12'hB00, 2'b10, 64'hF0, cyc});
        tick();
        clear_inst();
        check("pt_rs_result", mem[12'hB00], 64'h12F4);

        // same pipeline read while busy: blocked
        trap_req   = 1'b1;
        trap_pc    = 64'h8000_0300;
        trap_cause = 64'h5;
        n = cyc;
        exp_trap(n, 64'h8000_0300, 64'h5, 64'h1800, 64'h8000_0100);
        tick();
        trap_req          = 1'b0;
        bus.inst_csr_addr = 12'hB00;
        bus.inst_csr_rena = 1'b1;
        @(negedge clk);
        check("busy_rdata", bus.inst_csr_rdata, 64'h0);
        check("busy_rena",  64'(bus.csr_rena), 64'h0);
        check("busy_addr",  64'(bus.csr_addr), 64'h341);
        tick();
        clear_inst();
        repeat (7) tick();

        // trap_req held across S_REDIR is re-accepted on the first idle cycle
        trap_req   = 1'b1;
        trap_pc    = 64'h8000_0400;
        trap_cause = 64'h3;
        n = cyc;
        exp_trap(n,     64'h8000_0400, 64'h3, 64'h1800, 64'h8000_0100);
        exp_trap(n + 7, 64'h8000_0400, 64'h3, 64'h1800, 64'h8000_0100);
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i == 7) check("held_idle_busy", 64'(busy), 64'h0);
            if (i == 8) begin
                check("held_reaccept_busy", 64'(busy), 64'h1);
                trap_req = 1'b0;
            end
        end
        repeat (10) tick();
        check("final_rpc", redirect_pc, 64'h8000_0100);

        check("wr_q_drained", 64'(wr_q.size()), 64'h0);
        check("rd_q_drained", 64'(rd_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
